// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: walks the interior pixel centres of one stored frame
// in raster order, issues one ALU read per pixel and tracks ALU write-backs.
//
// Ports:
//   sys_clk      system clock
//   rst          asynchronous active-high reset
//   frame_start  one-cycle pulse, a new frame is stored and may be filtered
//   hold         read port unavailable this cycle, no request issued
//   abort        synchronous abort of the current frame
//   alu_wen      ALU write-back strobe, one per completed pixel
//   raddr_alu    centre-pixel read address to the ALU
//   ren_alu      read request valid
//   busy         high while reading (RUN) or waiting for writes (DRAIN)
//   frame_done   one-cycle pulse when a frame completes
//   timeout_err  sticky, set when write-backs never arrived in DRAIN
//   overrun      one-cycle pulse, frame_start seen while not idle
//   issue_cnt    requests issued in the current frame
module conv_frame_scheduler #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int AW        = 17,
    parameter int DRAIN_MAX = 64
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          hold,
    input  logic          abort,
    input  logic          alu_wen,
    output logic [AW-1:0] raddr_alu,
    output logic          ren_alu,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err,
    output logic          overrun,
    output logic [AW-1:0] issue_cnt
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    localparam logic [AW-1:0] NPIX    = AW'((IMG_W - 2) * (IMG_H - 2));
    localparam logic [AW-1:0] A_FIRST = AW'(IMG_W + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 2);
    localparam logic [DW-1:0] D_LAST  = DW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] r_issue;
    logic [AW-1:0] r_wcnt;
    logic [DW-1:0] r_dcnt;
    logic          r_timeout;

    logic          w_busy;
    logic          w_ren;
    logic          w_last;
    logic          w_start;
    logic [AW-1:0] w_wcnt_nxt;
    logic          w_wr_done;
    logic          w_to_set;

    assign w_busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_ren   = (r_state == S_RUN) && !hold;
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
    // abort outranks a simultaneous frame_start in IDLE
    assign w_start = (r_state == S_IDLE) && frame_start && !abort;

    // Write-backs count only while a frame is in flight and saturate at
    // the pixel total so late strays cannot wrap the counter.
    always_comb begin
        w_wcnt_nxt = r_wcnt;
        if (w_busy && alu_wen && (r_wcnt != NPIX)) begin
            w_wcnt_nxt = r_wcnt + 1'b1;
        end
    end

    // Uses the count including this cycle's strobe, so DONE follows the
    // final write-back by one cycle.
    assign w_wr_done = (w_wcnt_nxt == NPIX);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_set    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ren && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wr_done) begin
                    w_state_nxt = S_DONE;
                end else if (r_dcnt == D_LAST) begin
                    w_state_nxt = S_DONE;
                    w_to_set    = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_raddr   <= '0;
            r_issue   <= '0;
            r_wcnt    <= '0;
            r_dcnt    <= '0;
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_x       <= XW'(1);
            r_y       <= YW'(1);
            r_raddr   <= A_FIRST;
            r_issue   <= '0;
            r_wcnt    <= '0;
            r_dcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wcnt <= w_wcnt_nxt;
            if (w_ren) begin
                r_issue <= r_issue + 1'b1;
                // The final centre keeps its address through DRAIN.
                if (!w_last) begin
                    if (r_x != X_LAST) begin
                        r_x     <= r_x + 1'b1;
                        r_raddr <= r_raddr + 1'b1;
                    end else begin
                        // step over right border of this row and
                        // left border of the next
                        r_x     <= XW'(1);
                        r_y     <= r_y + 1'b1;
                        r_raddr <= r_raddr + AW'(3);
                    end
                end
            end
            if (r_state == S_DRAIN) begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign raddr_alu   = r_raddr;
    assign ren_alu     = w_ren;
    assign busy        = w_busy;
    assign frame_done  = (r_state == S_DONE);
    assign timeout_err = r_timeout;
    assign overrun     = frame_start && (r_state != S_IDLE);
    assign issue_cnt   = r_issue;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler: directed bench for conv_frame_scheduler on an
// 8x6 frame with a 3-cycle ALU write-back echo.
module tb_conv_frame_scheduler;

    localparam int W      = 8;
    localparam int H      = 6;
    localparam int AW     = 6;
    localparam int DM     = 16;
    localparam int N      = (W - 2) * (H - 2);
    localparam int LAST_A = (H - 2) * W + (W - 2);

    logic          sys_clk;
    logic          rst;
    logic          frame_start;
    logic          hold;
    logic          abort;
    logic          alu_wen;
    logic [AW-1:0] raddr_alu;
    logic          ren_alu;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic          overrun;
    logic [AW-1:0] issue_cnt;

    logic [2:0]    r_pipe;
    logic          wen_block;

    int n_checks;
    int n_fail;

    conv_frame_scheduler #(
        .IMG_W    (W),
        .IMG_H    (H),
        .AW       (AW),
        .DRAIN_MAX(DM)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .frame_start(frame_start),
        .hold       (hold),
        .abort      (abort),
        .alu_wen    (alu_wen),
        .raddr_alu  (raddr_alu),
        .ren_alu    (ren_alu),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout_err(timeout_err),
        .overrun    (overrun),
        .issue_cnt  (issue_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ALU model: each accepted read comes back as a write 3 cycles later
    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[1:0], ren_alu & ~wen_block};
        end
    end
    assign alu_wen = r_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic run_frame(input string name, input bit hold_alt,
                             input bit withhold, input int ovr_at,
                             input int exp_done, input bit exp_to);
        int ex, ea, issues;
        int addr_err, ren_err, ovr_err, ovr_n, dones, done_cyc;
        int to_at_done, ic_at_done, busy_at_done;
        bit fired;
        bit exp_ren;
        ex = 1; ea = W + 1; issues = 0;
        addr_err = 0; ren_err = 0; ovr_err = 0; ovr_n = 0;
        dones = 0; done_cyc = -1; fired = 0;
        to_at_done = -1; ic_at_done = -1; busy_at_done = -1;

        @(posedge sys_clk); #1;
        frame_start = 1'b1; hold = 1'b0; abort = 1'b0; wen_block = 1'b0;
        @(negedge sys_clk);
        chk({name, "_start_ovr"}, overrun, 0);
        chk({name, "_start_busy"}, busy, 0);
        @(posedge sys_clk); #1;
        frame_start = 1'b0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) begin
                @(posedge sys_clk); #1;
            end
            hold = hold_alt && (cyc % 2 == 1);
            frame_start = 1'b0;
            if (ovr_at >= 0 && !fired && issues == ovr_at) begin
                frame_start = 1'b1;
                fired = 1'b1;
            end
            @(negedge sys_clk);
            if (cyc == 0) begin
                chk({name, "_ic0"}, issue_cnt, 0);
                chk({name, "_to0"}, timeout_err, 0);
                chk({name, "_busy0"}, busy, 1);
            end
            exp_ren = (issues < N) && !hold;
            if (ren_alu !== exp_ren) ren_err++;
            if (issues < N && int'(raddr_alu) != ea) addr_err++;
            if (issues == N && int'(raddr_alu) != LAST_A) addr_err++;
            if (overrun !== frame_start) ovr_err++;
            if (overrun === 1'b1) ovr_n++;
            if (exp_ren) begin
                issues++;
                if (ex < W - 2) begin
                    ex++; ea++;
                end else begin
                    ex = 1; ea += 3;
                end
            end
            wen_block = withhold && (issues >= N - 1);
            if (frame_done === 1'b1) begin
                dones++;
                done_cyc = cyc;
                to_at_done = timeout_err;
                ic_at_done = issue_cnt;
                busy_at_done = busy;
                break;
            end
        end

        @(posedge sys_clk); #1;
        frame_start = 1'b0; hold = 1'b0;
        @(negedge sys_clk);
        chk({name, "_done_once"}, frame_done, 0);
        chk({name, "_idle_busy"}, busy, 0);

        chk({name, "_issues"}, issues, N);
        chk({name, "_addr_err"}, addr_err, 0);
        chk({name, "_ren_err"}, ren_err, 0);
        chk({name, "_ovr_err"}, ovr_err, 0);
        chk({name, "_ovr_n"}, ovr_n, (ovr_at >= 0) ? 1 : 0);
        chk({name, "_dones"}, dones, 1);
        chk({name, "_done_cyc"}, done_cyc, exp_done);
        chk({name, "_to"}, to_at_done, exp_to);
        chk({name, "_ic"}, ic_at_done, N);
        chk({name, "_busy_done"}, busy_at_done, 0);
    endtask

    initial begin
        int nd;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; frame_start = 1'b0; hold = 1'b0;
        abort = 1'b0; wen_block = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_raddr", raddr_alu, 0);
        chk("rst_ren", ren_alu, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ic", issue_cnt, 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;

        run_frame("basic", 0, 0, -1, 27, 0);
        run_frame("hold", 1, 0, -1, 50, 0);
        run_frame("drain_to", 0, 1, -1, 40, 1);
        run_frame("ovr", 0, 0, 10, 27, 0);

        // abort after five issues
        @(posedge sys_clk); #1;
        frame_start = 1'b1;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 abort = 1'b1;
        @(negedge sys_clk);
        chk("abort_busy_pre", busy, 1);
        @(posedge sys_clk); #1;
        abort = 1'b0;
        @(negedge sys_clk);
        chk("abort_ren", ren_alu, 0);
        chk("abort_busy", busy, 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (frame_done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_frame("restart", 0, 0, -1, 27, 0);

        // abort beats frame_start in IDLE
        @(posedge sys_clk); #1;
        frame_start = 1'b1; abort = 1'b1;
        @(posedge sys_clk); #1;
        frame_start = 1'b0; abort = 1'b0;
        @(negedge sys_clk);
        chk("abort_wins_busy", busy, 0);
        chk("abort_wins_ren", ren_alu, 0);

        // asynchronous reset in the middle of RUN
        @(posedge sys_clk); #1;
        frame_start = 1'b1;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("pre_rst_raddr", raddr_alu, 12);
        #2 rst = 1'b1;
        #1;
        chk("arst_raddr", raddr_alu, 0);
        chk("arst_ren", ren_alu, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ic", issue_cnt, 0);
        chk("arst_done", frame_done, 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        run_frame("post_rst", 0, 0, -1, 27, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
